// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of committed stores in front of the TCM write port, with load forwarding.
// Latency: a pushed store reaches stbuf_bus_wr one cycle later; lookup answers combinationally.
// Backpressure: push_ready drops at count==DEPTH; the head is held until bus_stbuf_write_ready.
// Optional feature macro: STORE_BUFFER_FORWARD_EN (data forwarding; undefined = overlap forces replay).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module store_buffer #(
  parameter int DEPTH     = 8,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [`ADDR_WIDTH-1:0]     push_addr,
  input  logic [`SIZE_WIDTH-1:0]     push_size,
  input  logic [`REG_DATA_WIDTH-1:0] push_data,
  output logic                       stbuf_bus_wr,
  output logic [`ADDR_WIDTH-1:0]     stbuf_bus_write_addr,
  output logic [`SIZE_WIDTH-1:0]     stbuf_bus_write_size,
  output logic [`REG_DATA_WIDTH-1:0] stbuf_bus_data,
  input  logic                       bus_stbuf_write_ready,
  input  logic                       lookup_valid,
  input  logic [`ADDR_WIDTH-1:0]     lookup_addr,
  input  logic [`SIZE_WIDTH-1:0]     lookup_size,
  output logic                       lookup_hit,
  output logic                       lookup_conflict,
  output logic [`REG_DATA_WIDTH-1:0] lookup_data,
  output logic                       empty,
  output logic [PTR_WIDTH:0]         count
);

  localparam int AW = `ADDR_WIDTH;
  localparam int SW = `SIZE_WIDTH;
  localparam int DW = `REG_DATA_WIDTH;
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);

  // Entry storage; valid bits mark the occupied window head..tail-1.
  logic [AW-1:0]        r_addr [DEPTH];
  logic [SW-1:0]        r_size [DEPTH];
  logic [DW-1:0]        r_data [DEPTH];
  logic [DEPTH-1:0]     r_valid;
  logic [PTR_WIDTH-1:0] r_head;
  logic [PTR_WIDTH-1:0] r_tail;
  logic [PTR_WIDTH:0]   r_count;

  logic w_empty;
  logic w_push_ready;
  logic w_push;
  logic w_pop;

  // Only 1/2/4-byte accesses take part in forwarding; anything else just passes through.
  function automatic logic size_ok(input logic [SW-1:0] s);
    return (s == SW'(1)) || (s == SW'(2)) || (s == SW'(4));
  endfunction

  assign w_empty      = (r_count == '0);
  assign w_push_ready = (r_count != FULL_COUNT);
  assign w_push       = push_valid && w_push_ready;
  assign w_pop        = !w_empty && bus_stbuf_write_ready;

  assign push_ready   = w_push_ready;
  assign empty        = w_empty;
  assign count        = r_count;

  // Head/tail pointers and occupancy; a push refused while full stays refused even if a pop happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_WIDTH'(1);
      if (w_pop)  r_head <= r_head + PTR_WIDTH'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_WIDTH+1)'(1);
        2'b01:   r_count <= r_count - (PTR_WIDTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry write at tail and valid-bit maintenance; push and pop never target the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_size[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= push_addr;
        r_size[r_tail]  <= push_size;
        r_data[r_tail]  <= push_data;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
      end
    end
  end

  // Drain channel comes straight from registered head storage, zeroed when nothing is buffered.
  assign stbuf_bus_wr         = !w_empty;
  assign stbuf_bus_write_addr = w_empty ? '0 : r_addr[r_head];
  assign stbuf_bus_write_size = w_empty ? '0 : r_size[r_head];
  assign stbuf_bus_data       = w_empty ? '0 : r_data[r_head];

  // Byte ranges [addr, addr+size) are compared one bit wider so the end address cannot wrap.
  logic [AW:0]      w_ld_lo;
  logic [AW:0]      w_ld_hi;
  logic             w_ld_size_ok;
  logic [AW:0]      w_st_lo [DEPTH];
  logic [AW:0]      w_st_hi [DEPTH];
  logic [DEPTH-1:0] w_ovl;

  // Per-entry overlap against the load range, over every valid entry including an accepting head.
  always_comb begin
    w_ld_lo      = {1'b0, lookup_addr};
    w_ld_hi      = w_ld_lo + (AW+1)'(lookup_size);
    w_ld_size_ok = size_ok(lookup_size);
    for (int i = 0; i < DEPTH; i++) begin
      w_st_lo[i] = {1'b0, r_addr[i]};
      w_st_hi[i] = w_st_lo[i] + (AW+1)'(r_size[i]);
      w_ovl[i]   = r_valid[i] && size_ok(r_size[i]) && w_ld_size_ok &&
                   (w_st_lo[i] < w_ld_hi) && (w_ld_lo < w_st_hi[i]);
    end
  end

`ifdef STORE_BUFFER_FORWARD_EN
  logic [DEPTH-1:0]     w_cov;
  logic                 w_sel_found;
  logic [PTR_WIDTH-1:0] w_sel_idx;
  logic [PTR_WIDTH-1:0] w_scan_idx;
  logic [1:0]           w_off;
  logic [DW-1:0]        w_shift;
  logic [DW-1:0]        w_mask;

  // Full-cover test: the store range must contain the whole load range.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_cov[i] = w_ovl[i] && (w_st_lo[i] <= w_ld_lo) && (w_ld_hi <= w_st_hi[i]);
    end
  end

  // Walk oldest to youngest so the last overlapping entry seen is the youngest one.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = r_head;
    w_scan_idx  = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan_idx = r_head + PTR_WIDTH'(i);
      if (w_ovl[w_scan_idx]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_scan_idx;
      end
    end
  end

  // Align the selected store's bytes to the load address and trim to the load size.
  always_comb begin
    w_off   = lookup_addr[1:0] - r_addr[w_sel_idx][1:0];
    w_shift = r_data[w_sel_idx] >> {w_off, 3'b000};
    case (lookup_size)
      SW'(1):  w_mask = DW'(8'hFF);
      SW'(2):  w_mask = DW'(16'hFFFF);
      default: w_mask = '1;
    endcase
  end

  assign lookup_hit      = lookup_valid && w_sel_found && w_cov[w_sel_idx];
  assign lookup_conflict = lookup_valid && w_sel_found && !w_cov[w_sel_idx];
  assign lookup_data     = lookup_hit ? (w_shift & w_mask) : '0;
`else
  // Without forwarding, any overlap with a buffered store sends the load back for replay.
  assign lookup_hit      = 1'b0;
  assign lookup_conflict = lookup_valid && (|w_ovl);
  assign lookup_data     = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed table, hand sequences and randomized traffic against a queue model.
// Inputs change on the falling edge; outputs are sampled 2 time units later.
// Model state advances on the rising edge from the inputs the bench applied.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 3
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module tb_store_buffer;
  localparam int DEPTH = 8;
`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_addr;
  logic [2:0]  push_size;
  logic [31:0] push_data;
  logic        stbuf_bus_wr;
  logic [31:0] stbuf_bus_write_addr;
  logic [2:0]  stbuf_bus_write_size;
  logic [31:0] stbuf_bus_data;
  logic        bus_stbuf_write_ready;
  logic        lookup_valid;
  logic [31:0] lookup_addr;
  logic [2:0]  lookup_size;
  logic        lookup_hit;
  logic        lookup_conflict;
  logic [31:0] lookup_data;
  logic        empty;
  logic [3:0]  count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_size(push_size), .push_data(push_data),
    .stbuf_bus_wr(stbuf_bus_wr), .stbuf_bus_write_addr(stbuf_bus_write_addr),
    .stbuf_bus_write_size(stbuf_bus_write_size), .stbuf_bus_data(stbuf_bus_data),
    .bus_stbuf_write_ready(bus_stbuf_write_ready),
    .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_size(lookup_size),
    .lookup_hit(lookup_hit), .lookup_conflict(lookup_conflict), .lookup_data(lookup_data),
    .empty(empty), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } st_t;

  typedef struct {
    logic pv; logic [31:0] pa; logic [2:0] ps; logic [31:0] pd;
    logic rdy; logic lv; logic [31:0] la; logic [2:0] ls;
    logic e_prdy; logic e_wr; logic [31:0] e_baddr; logic [2:0] e_bsize; logic [31:0] e_bdata;
    logic [3:0] e_count; logic e_hit; logic e_conf; logic [31:0] e_ldata;
  } vec_t;

  st_t  q[$];
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[23];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit size_ok(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd2) || (s == 3'd4);
  endfunction

  // Reference lookup: youngest overlapping store decides; bytes gathered one at a time.
  function automatic void model_lookup(input logic lv, input logic [31:0] la, input logic [2:0] ls,
                                       output logic hit, output logic conf, output logic [31:0] data);
    longint l_lo, l_hi, s_lo, s_hi;
    hit = 1'b0; conf = 1'b0; data = '0;
    if (!lv || !size_ok(ls)) return;
    l_lo = longint'(la);
    l_hi = l_lo + longint'(ls);
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (!size_ok(q[k].size)) continue;
      s_lo = longint'(q[k].addr);
      s_hi = s_lo + longint'(q[k].size);
      if (s_lo < l_hi && l_lo < s_hi) begin
        if (FWD && s_lo <= l_lo && l_hi <= s_hi) begin
          hit = 1'b1;
          for (int b = 0; b < int'(ls); b++)
            data[8*b +: 8] = q[k].data[8*(int'(l_lo - s_lo) + b) +: 8];
        end else begin
          conf = 1'b1;
        end
        return;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    logic eh, ec;
    logic [31:0] ed;
    st_t h;
    h = '{32'h0, 3'h0, 32'h0};
    if (q.size() != 0) h = q[0];
    model_lookup(lookup_valid, lookup_addr, lookup_size, eh, ec, ed);
    chk({tag, " push_ready"}, 64'(push_ready), 64'(q.size() < DEPTH));
    chk({tag, " bus_wr"}, 64'(stbuf_bus_wr), 64'(q.size() != 0));
    chk({tag, " bus_addr"}, 64'(stbuf_bus_write_addr), 64'(h.addr));
    chk({tag, " bus_size"}, 64'(stbuf_bus_write_size), 64'(h.size));
    chk({tag, " bus_data"}, 64'(stbuf_bus_data), 64'(h.data));
    chk({tag, " count"}, 64'(count), 64'(q.size()));
    chk({tag, " empty"}, 64'(empty), 64'(q.size() == 0));
    chk({tag, " hit"}, 64'(lookup_hit), 64'(eh));
    chk({tag, " conflict"}, 64'(lookup_conflict), 64'(ec));
    chk({tag, " ldata"}, 64'(lookup_data), 64'(ed));
  endtask

  task automatic drive(input logic pv, input logic [31:0] pa, input logic [2:0] ps, input logic [31:0] pd,
                       input logic rdy, input logic lv, input logic [31:0] la, input logic [2:0] ls);
    push_valid = pv; push_addr = pa; push_size = ps; push_data = pd;
    bus_stbuf_write_ready = rdy;
    lookup_valid = lv; lookup_addr = la; lookup_size = ls;
  endtask

  // Advance one clock and update the model from the inputs that were applied.
  task automatic tick();
    bit do_push, do_pop;
    @(posedge clk);
    do_push = push_valid && (q.size() < DEPTH);
    do_pop  = (q.size() != 0) && bus_stbuf_write_ready;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{push_addr, push_size, push_data});
    @(negedge clk);
  endtask

  function automatic vec_t v(input logic pv, input logic [31:0] pa, input logic [2:0] ps, input logic [31:0] pd,
                             input logic rdy, input logic lv, input logic [31:0] la, input logic [2:0] ls,
                             input logic e_prdy, input logic e_wr, input logic [31:0] e_baddr,
                             input logic [2:0] e_bsize, input logic [31:0] e_bdata, input logic [3:0] e_count,
                             input logic e_hit, input logic e_conf, input logic [31:0] e_ldata);
    vec_t r;
    r.pv = pv; r.pa = pa; r.ps = ps; r.pd = pd; r.rdy = rdy; r.lv = lv; r.la = la; r.ls = ls;
    r.e_prdy = e_prdy; r.e_wr = e_wr; r.e_baddr = e_baddr; r.e_bsize = e_bsize; r.e_bdata = e_bdata;
    r.e_count = e_count; r.e_hit = e_hit; r.e_conf = e_conf; r.e_ldata = e_ldata;
    return r;
  endfunction

  initial begin
    int wr_seen;
    int r;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;

    // Directed table: each row is the inputs for one cycle and the outputs expected before its edge.
    tbl[0]  = v(0, 32'h0,   0, 32'h0,        1, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0);
    tbl[1]  = v(1, 32'h100, 4, 32'hDEADBEEF, 1, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0);
    tbl[2]  = v(0, 32'h0,   0, 32'h0,        1, 0, 32'h0,   0, 1, 1, 32'h100, 4, 32'hDEADBEEF, 1, 0, 0, 32'h0);
    tbl[3]  = v(0, 32'h0,   0, 32'h0,        0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0);
    tbl[4]  = v(1, 32'h200, 4, 32'h11223344, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0);
    tbl[5]  = v(1, 32'h201, 1, 32'h000000AA, 0, 0, 32'h0,   0, 1, 1, 32'h200, 4, 32'h11223344, 1, 0, 0, 32'h0);
    tbl[6]  = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h201, 1, 1, 1, 32'h200, 4, 32'h11223344, 2, FWD, !FWD, FWD ? 32'hAA : 32'h0);
    tbl[7]  = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h202, 2, 1, 1, 32'h200, 4, 32'h11223344, 2, FWD, !FWD, FWD ? 32'h1122 : 32'h0);
    tbl[8]  = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h200, 4, 1, 1, 32'h200, 4, 32'h11223344, 2, 0, 1, 32'h0);
    tbl[9]  = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h204, 4, 1, 1, 32'h200, 4, 32'h11223344, 2, 0, 0, 32'h0);
    tbl[10] = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h1FF, 2, 1, 1, 32'h200, 4, 32'h11223344, 2, 0, 1, 32'h0);
    tbl[11] = v(0, 32'h0,   0, 32'h0,        1, 0, 32'h0,   0, 1, 1, 32'h200, 4, 32'h11223344, 2, 0, 0, 32'h0);
    tbl[12] = v(0, 32'h0,   0, 32'h0,        1, 1, 32'h200, 1, 1, 1, 32'h201, 1, 32'h000000AA, 1, 0, 0, 32'h0);
    tbl[13] = v(1, 32'h300, 2, 32'h0000BEEF, 0, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0);
    tbl[14] = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h301, 2, 1, 1, 32'h300, 2, 32'h0000BEEF, 1, 0, 1, 32'h0);
    tbl[15] = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h304, 4, 1, 1, 32'h300, 2, 32'h0000BEEF, 1, 0, 0, 32'h0);
    tbl[16] = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h300, 2, 1, 1, 32'h300, 2, 32'h0000BEEF, 1, FWD, !FWD, FWD ? 32'hBEEF : 32'h0);
    tbl[17] = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h2FF, 1, 1, 1, 32'h300, 2, 32'h0000BEEF, 1, 0, 0, 32'h0);
    tbl[18] = v(0, 32'h0,   0, 32'h0,        0, 0, 32'h300, 2, 1, 1, 32'h300, 2, 32'h0000BEEF, 1, 0, 0, 32'h0);
    tbl[19] = v(0, 32'h0,   0, 32'h0,        0, 1, 32'h300, 3, 1, 1, 32'h300, 2, 32'h0000BEEF, 1, 0, 0, 32'h0);
    tbl[20] = v(0, 32'h0,   0, 32'h0,        1, 1, 32'h300, 2, 1, 1, 32'h300, 2, 32'h0000BEEF, 1, FWD, !FWD, FWD ? 32'hBEEF : 32'h0);
    tbl[21] = v(0, 32'h0,   0, 32'h0,        1, 0, 32'h0,   0, 1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0);
    tbl[22] = v(0, 32'h0,   0, 32'h0,        1, 1, 32'h300, 2, 1, 0, 32'h0,   0, 32'h0,        0, 0, 0, 32'h0);

    // Reset state.
    #2;
    chk("reset push_ready", 64'(push_ready), 64'(1));
    chk("reset bus_wr", 64'(stbuf_bus_wr), 64'(0));
    chk("reset count", 64'(count), 64'(0));
    chk("reset empty", 64'(empty), 64'(1));
    chk("reset bus_addr", 64'(stbuf_bus_write_addr), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].pv, tbl[i].pa, tbl[i].ps, tbl[i].pd, tbl[i].rdy, tbl[i].lv, tbl[i].la, tbl[i].ls);
      #2;
      chk($sformatf("tbl%0d push_ready", i), 64'(push_ready), 64'(tbl[i].e_prdy));
      chk($sformatf("tbl%0d bus_wr", i), 64'(stbuf_bus_wr), 64'(tbl[i].e_wr));
      chk($sformatf("tbl%0d bus_addr", i), 64'(stbuf_bus_write_addr), 64'(tbl[i].e_baddr));
      chk($sformatf("tbl%0d bus_size", i), 64'(stbuf_bus_write_size), 64'(tbl[i].e_bsize));
      chk($sformatf("tbl%0d bus_data", i), 64'(stbuf_bus_data), 64'(tbl[i].e_bdata));
      chk($sformatf("tbl%0d count", i), 64'(count), 64'(tbl[i].e_count));
      chk($sformatf("tbl%0d empty", i), 64'(empty), 64'(tbl[i].e_count == 0));
      chk($sformatf("tbl%0d hit", i), 64'(lookup_hit), 64'(tbl[i].e_hit));
      chk($sformatf("tbl%0d conflict", i), 64'(lookup_conflict), 64'(tbl[i].e_conf));
      chk($sformatf("tbl%0d ldata", i), 64'(lookup_data), 64'(tbl[i].e_ldata));
      tick();
    end

    // Fill to DEPTH with the bus stalled, then offer a push on the same cycle as the first pop.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 32'h400 + 32'(4*k), 4, 32'hA0000000 | 32'(k), 0, 0, 0, 0);
      #2;
      check_model($sformatf("fill%0d", k));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("full count", 64'(count), 64'(8));
    chk("full push_ready", 64'(push_ready), 64'(0));
    drive(1, 32'h999, 4, 32'h99999999, 1, 0, 0, 0);
    #2;
    chk("full pop push_ready", 64'(push_ready), 64'(0));
    chk("drain order 0", 64'(stbuf_bus_write_addr), 64'(32'h400));
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    #2;
    chk("refused push count", 64'(count), 64'(7));
    for (int k = 1; k < DEPTH; k++) begin
      chk($sformatf("drain order %0d", k), 64'(stbuf_bus_write_addr), 64'(32'h400 + 32'(4*k)));
      chk($sformatf("drain data %0d", k), 64'(stbuf_bus_data), 64'(32'hA0000000 | 32'(k)));
      check_model($sformatf("drain%0d", k));
      tick();
    end
    #2;
    chk("drained empty", 64'(empty), 64'(1));

    // Reset in the middle of a drain with three entries buffered.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h600 + 32'(4*k), 4, 32'h600 + 32'(k), 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    #2;
    chk("pre-reset count", 64'(count), 64'(3));
    chk("pre-reset bus_wr", 64'(stbuf_bus_wr), 64'(1));
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid reset bus_wr", 64'(stbuf_bus_wr), 64'(0));
    chk("mid reset count", 64'(count), 64'(0));
    chk("mid reset empty", 64'(empty), 64'(1));
    chk("mid reset push_ready", 64'(push_ready), 64'(1));
    chk("mid reset bus_data", 64'(stbuf_bus_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wr_seen = 0;
    for (int k = 0; k < 5; k++) begin
      #2;
      if (stbuf_bus_wr) wr_seen++;
      tick();
    end
    chk("post-reset writes", 64'(wr_seen), 64'(0));
    chk("post-reset count", 64'(count), 64'(0));

    // Randomized traffic against the model; a narrow address window keeps overlaps frequent.
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] ps, ls;
      r = $urandom_range(0, 9);
      ps = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : (r < 9) ? 3'd4 : 3'd3;
      r = $urandom_range(0, 9);
      ls = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : (r < 9) ? 3'd4 : 3'd0;
      drive($urandom_range(0, 99) < 60, 32'h500 + 32'($urandom_range(0, 15)), ps, $urandom,
            $urandom_range(0, 99) < ((n < 700) ? 30 : 65),
            $urandom_range(0, 99) < 70, 32'h500 + 32'($urandom_range(0, 15)), ls);
      #2;
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
